// File: rtl/uart_alu_stream.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_stream
// Purpose  : Packet-level byte-stream ALU (echo / add / multiply / drain)
//            sitting between a UART RX and TX ready/valid byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_stream #(
    parameter int         WORD_W  = 32,
    parameter logic [7:0] OP_ECHO = 8'hEC,
    parameter logic [7:0] OP_ADD  = 8'hA0,
    parameter logic [7:0] OP_MUL  = 8'hA1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic [7:0] data_o,
    input  logic       ready_i
);

    localparam int BYTES = WORD_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RSVD   = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_LEN_HI = 3'd3;
    localparam logic [2:0] S_ECHO   = 3'd4;
    localparam logic [2:0] S_ACC    = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;
    localparam logic [2:0] S_DRAIN  = 3'd7;

    logic [2:0]        r_state;
    logic [7:0]        r_opcode;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_rem;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_acc;
    logic              r_valid_o;
    logic [7:0]        r_data_o;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [15:0]       w_len;
    logic [15:0]       w_pay;
    logic              w_is_arith;
    logic [WORD_W-1:0] w_acc_init;
    logic [WORD_W-1:0] w_word_asm;
    logic [WORD_W-1:0] w_acc_calc;
    logic [WORD_W-1:0] w_acc_shift;
    logic              w_last;
    logic              w_word_done;

    assign valid_o    = r_valid_o;
    assign data_o     = r_data_o;
    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = r_valid_o & ready_i;

    assign w_len       = {data_i, r_len_lo};
    assign w_pay       = (w_len > 16'd4) ? (w_len - 16'd4) : 16'd0;
    assign w_is_arith  = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
    assign w_acc_init  = (r_opcode == OP_MUL) ? WORD_W'(1) : '0;
    assign w_last      = (r_rem == 16'd1);
    assign w_word_done = (r_idx == IDX_W'(BYTES - 1)) || w_last;
    assign w_acc_shift = r_acc >> 8;

    // Little-endian word assembly; untouched upper bytes stay zero for a partial word.
    always_comb begin
        w_word_asm = r_word;
        for (int b = 0; b < BYTES; b++) begin
            if (r_idx == IDX_W'(b)) begin
                w_word_asm[8*b +: 8] = data_i;
            end
        end
    end

    always_comb begin
        w_acc_calc = r_acc + w_word_asm;
        if (r_opcode == OP_MUL) begin
            w_acc_calc = r_acc * w_word_asm;
        end
    end

    // ECHO stops accepting once all payload is in, so the next opcode waits for TX.
    always_comb begin
        ready_o = 1'b0;
        if (!reset_i) begin
            case (r_state)
                S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ACC, S_DRAIN: ready_o = 1'b1;
                S_ECHO:   ready_o = (r_rem != 16'd0) && (!r_valid_o || ready_i);
                default:  ready_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_opcode  <= 8'd0;
            r_len_lo  <= 8'd0;
            r_rem     <= 16'd0;
            r_idx     <= '0;
            r_word    <= '0;
            r_acc     <= '0;
            r_valid_o <= 1'b0;
            r_data_o  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_opcode <= data_i;
                        r_state  <= S_RSVD;
                    end
                end
                S_RSVD: begin
                    if (w_in_fire) begin
                        r_state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_in_fire) begin
                        r_len_lo <= data_i;
                        r_state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_in_fire) begin
                        r_rem  <= w_pay;
                        r_idx  <= '0;
                        r_word <= '0;
                        if (r_opcode == OP_ECHO) begin
                            r_state <= (w_pay == 16'd0) ? S_IDLE : S_ECHO;
                        end else if (w_is_arith) begin
                            r_acc <= w_acc_init;
                            if (w_pay == 16'd0) begin
                                r_state   <= S_RESULT;
                                r_valid_o <= 1'b1;
                                r_data_o  <= w_acc_init[7:0];
                            end else begin
                                r_state <= S_ACC;
                            end
                        end else begin
                            r_state <= (w_pay == 16'd0) ? S_IDLE : S_DRAIN;
                        end
                    end
                end
                S_ECHO: begin
                    if (w_in_fire) begin
                        r_data_o  <= data_i;
                        r_valid_o <= 1'b1;
                        r_rem     <= r_rem - 16'd1;
                    end else if (w_out_fire) begin
                        r_valid_o <= 1'b0;
                        if (r_rem == 16'd0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ACC: begin
                    if (w_in_fire) begin
                        r_rem <= r_rem - 16'd1;
                        if (w_word_done) begin
                            r_acc  <= w_acc_calc;
                            r_word <= '0;
                            r_idx  <= '0;
                        end else begin
                            r_word <= w_word_asm;
                            r_idx  <= r_idx + IDX_W'(1);
                        end
                        if (w_last) begin
                            r_state   <= S_RESULT;
                            r_valid_o <= 1'b1;
                            r_data_o  <= w_acc_calc[7:0];
                        end
                    end
                end
                S_RESULT: begin
                    // r_acc shifts down so the next byte to send is always its low byte.
                    if (w_out_fire) begin
                        r_acc    <= w_acc_shift;
                        r_data_o <= w_acc_shift[7:0];
                        if (r_idx == IDX_W'(BYTES - 1)) begin
                            r_valid_o <= 1'b0;
                            r_idx     <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_in_fire) begin
                        r_rem <= r_rem - 16'd1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_stream
// Purpose  : Scoreboard bench for uart_alu_stream (WORD_W = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_stream;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = 8'd0;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i = 1'b1;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  pl[$];
    int          sink_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit          gap_en = 1'b0;
    bit          hold_seen = 1'b0;
    logic [7:0]  hold_data = 8'd0;

    uart_alu_stream #(.WORD_W(32)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #2;
        case (sink_mode)
            1:       ready_i = 1'($urandom_range(0, 1));
            2:       ready_i = 1'b0;
            default: ready_i = 1'b1;
        endcase
    end

    // Output monitor: pops the scoreboard on every TX transfer and checks hold stability.
    always @(negedge clk_i) begin
        if (valid_o && hold_seen) tb_check("tx_hold", data_o, hold_data);
        hold_seen = valid_o && !ready_i;
        hold_data = data_o;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) tb_check("tx_extra", data_o, 32'hDEAD);
            else                   tb_check("tx_byte", data_o, exp_q.pop_front());
        end
    end

    task automatic put_byte(input logic [7:0] b);
        bit ok;
        int n;
        if (gap_en) begin
            valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end
        valid_i = 1'b1;
        data_i  = b;
        n = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk_i);
            ok = ready_o;
            @(posedge clk_i);
            #1;
            n++;
            if (!ok && n > 200) begin
                tb_check("rx_timeout", 0, 1);
                ok = 1'b1;
            end
        end
        valid_i = 1'b0;
    endtask

    // Reference model: queues the expected TX bytes for the packet held in pl.
    task automatic model_pkt(input logic [7:0] op);
        logic [31:0] acc, w;
        if (op == 8'hEC) begin
            foreach (pl[i]) exp_q.push_back(pl[i]);
        end else if (op == 8'hA0 || op == 8'hA1) begin
            acc = (op == 8'hA1) ? 32'd1 : 32'd0;
            for (int i = 0; i < pl.size(); i += 4) begin
                w = 32'd0;
                for (int k = 0; k < 4; k++)
                    if (i + k < pl.size()) w[8*k +: 8] = pl[i+k];
                acc = (op == 8'hA1) ? acc * w : acc + w;
            end
            for (int k = 0; k < 4; k++) exp_q.push_back(acc[8*k +: 8]);
        end
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [15:0] len);
        model_pkt(op);
        put_byte(op);
        put_byte(8'h00);
        put_byte(len[7:0]);
        put_byte(len[15:8]);
        foreach (pl[i]) put_byte(pl[i]);
    endtask

    task automatic drain_wait;
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) tb_check("tx_timeout", exp_q.size(), 0);
        repeat (6) @(posedge clk_i);
        #1;
        tb_check("idle_valid", valid_o, 0);
        tb_check("idle_ready", ready_o, 1);
    endtask

    task automatic test_add_pair;
        pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt(8'hA0, 16'd12);
        drain_wait();
        pl = '{8'hAB, 8'hCD};
        send_pkt(8'hA0, 16'd6);
        drain_wait();
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        tb_check("rst_valid", valid_o, 0);
        tb_check("rst_data", data_o, 0);
        tb_check("rst_ready", ready_o, 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        tb_check("post_rst_ready", ready_o, 1);
        @(posedge clk_i);
        #1;

        // 1. Echo with a TX stall after the first byte
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        put_byte(8'hEC); put_byte(8'h00); put_byte(8'h07); put_byte(8'h00);
        put_byte(8'h11);
        sink_mode = 2;
        valid_i = 1'b1;
        data_i  = 8'h22;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            tb_check("stall_ready", ready_o, 0);
            tb_check("stall_valid", valid_o, 1);
            tb_check("stall_data", data_o, 8'h11);
        end
        sink_mode = 0;
        put_byte(8'h22);
        put_byte(8'h33);
        drain_wait();

        // 2. Add, full and partial words
        test_add_pair();

        // 3. Multiply and empty-payload arithmetic
        pl = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt(8'hA1, 16'd12);
        drain_wait();
        pl = {};
        send_pkt(8'hA1, 16'd4);
        drain_wait();
        send_pkt(8'hA0, 16'd4);
        drain_wait();
        pl = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h02, 8'h00, 8'h00, 8'h80, 8'h07};
        send_pkt(8'hA1, 16'd13);
        drain_wait();

        // 4. Unknown opcode drained, then echo
        pl = '{8'hEC, 8'hA0, 8'h04, 8'h00, 8'h99};
        send_pkt(8'h55, 16'd9);
        pl = '{8'h7E};
        send_pkt(8'hEC, 16'd5);
        drain_wait();

        // 5. Reset in the middle of an add payload
        put_byte(8'hA0); put_byte(8'h00); put_byte(8'h0C); put_byte(8'h00);
        put_byte(8'h12); put_byte(8'h34);
        reset_i = 1'b1;
        @(negedge clk_i);
        tb_check("midrst_ready", ready_o, 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        tb_check("midrst_valid", valid_o, 0);
        @(posedge clk_i);
        #1;
        pl = '{8'h42};
        send_pkt(8'hEC, 16'd5);
        drain_wait();

        // 6. Short LEN for echo and unknown opcode, longer drain
        pl = {};
        send_pkt(8'hEC, 16'd2);
        drain_wait();
        send_pkt(8'h55, 16'd2);
        drain_wait();
        for (int i = 0; i < 300; i++) pl.push_back(8'(i));
        send_pkt(8'h33, 16'd304);
        pl = '{8'h5A, 8'hA5};
        send_pkt(8'hEC, 16'd6);
        drain_wait();

        // Random valid/ready gaps on the add sequence
        gap_en = 1'b1;
        sink_mode = 1;
        test_add_pair();
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_pkt(8'hEC, 16'd8);
        drain_wait();
        sink_mode = 0;
        gap_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
